// File: rtl/board_input_conditioner.sv
// Synchronises, debounces and edge-detects the raw DE1-SoC keys and switches
// feeding the soc_system board_key/board_sw conduit.
module board_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] key_n_raw,
  input  logic [9:0] sw_raw,
  output logic [3:0] board_key,
  output logic [9:0] board_sw,
  output logic [3:0] key_press,
  input  logic [3:0] key_press_clr,
  output logic       input_changed
);

  localparam int unsigned NumCh = 14;
  // Keys idle high on the pins; switches idle low. XOR with this also inverts the keys.
  localparam logic [NumCh-1:0] SyncRst = {10'b0, 4'hF};
  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] s1_q, s2_q;
  logic [NumCh-1:0] sync;
  logic [NumCh-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NumCh];
  logic [CNT_W-1:0] cnt_d [NumCh];
  logic [3:0]       press_ev;
  logic [3:0]       key_press_q, key_press_d;
  logic             changed_q, changed_d;

  assign raw  = {sw_raw, key_n_raw};
  assign sync = s2_q ^ SyncRst;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q <= SyncRst;
      s2_q <= SyncRst;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Any return of sync to stable before terminal count restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumCh; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == TermCnt) begin
          stable_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    press_ev    = stable_d[3:0] & ~stable_q[3:0];
    key_press_d = press_ev | (key_press_q & ~key_press_clr);
    changed_d   = |(stable_d ^ stable_q);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q    <= '0;
      key_press_q <= '0;
      changed_q   <= 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q    <= stable_d;
      key_press_q <= key_press_d;
      changed_q   <= changed_d;
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign board_key     = stable_q[3:0];
  assign board_sw      = stable_q[13:4];
  assign key_press     = key_press_q;
  assign input_changed = changed_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Table-driven bench for board_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_board_input_conditioner;

  typedef struct {
    logic [3:0] key_n;
    logic [9:0] sw;
    logic [3:0] clr;
    int         cycles;
    bit         rst_before;
    logic [3:0] exp_key;
    logic [9:0] exp_sw;
    logic [3:0] exp_press;
    int         exp_pulses;
    string      name;
  } vec_t;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic [3:0] key_n_raw = 4'hF;
  logic [9:0] sw_raw = '0;
  logic [3:0] key_press_clr = '0;
  logic [3:0] board_key;
  logic [9:0] board_sw;
  logic [3:0] key_press;
  logic       input_changed;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  vec_t sb[$];

  board_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .key_n_raw    (key_n_raw),
    .sw_raw       (sw_raw),
    .board_key    (board_key),
    .board_sw     (board_sw),
    .key_press    (key_press),
    .key_press_clr(key_press_clr),
    .input_changed(input_changed)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic vec_t mk(input logic [3:0] key_n, input logic [9:0] sw,
                              input logic [3:0] clr, input int cycles, input bit rst_before,
                              input logic [3:0] exp_key, input logic [9:0] exp_sw,
                              input logic [3:0] exp_press, input int exp_pulses,
                              input string name);
    vec_t v;
    v.key_n = key_n; v.sw = sw; v.clr = clr; v.cycles = cycles; v.rst_before = rst_before;
    v.exp_key = exp_key; v.exp_sw = exp_sw; v.exp_press = exp_press;
    v.exp_pulses = exp_pulses; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Assert reset mid-cycle while a count is in flight, then release on a falling edge.
  task automatic mid_count_reset(input string name);
    #2 reset_reset_n = 1'b0;
    #1;
    check({name, " rst board_key"}, int'(board_key), 0);
    check({name, " rst board_sw"}, int'(board_sw), 0);
    check({name, " rst key_press"}, int'(key_press), 0);
    check({name, " rst input_changed"}, int'(input_changed), 0);
    @(negedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int   pulses;
    vec_t e;
    if (v.rst_before) mid_count_reset(v.name);
    key_n_raw     = v.key_n;
    sw_raw        = v.sw;
    key_press_clr = v.clr;
    sb.push_back(v);
    pulses = 0;
    for (int c = 0; c < v.cycles; c++) begin
      @(posedge clk_clk);
      @(negedge clk_clk);
      if (input_changed) pulses++;
    end
    e = sb.pop_front();
    check({e.name, " board_key"}, int'(board_key), int'(e.exp_key));
    check({e.name, " board_sw"}, int'(board_sw), int'(e.exp_sw));
    check({e.name, " key_press"}, int'(key_press), int'(e.exp_press));
    check({e.name, " change pulses"}, pulses, e.exp_pulses);
  endtask

  initial begin
    // Power-on switch reaches the output after edge 6 with one change pulse.
    tbl.push_back(mk(4'hF, 10'h201, 4'h0, 5, 0, 4'h0, 10'h000, 4'h0, 0, "s1 pre"));
    tbl.push_back(mk(4'hF, 10'h201, 4'h0, 1, 0, 4'h0, 10'h201, 4'h0, 1, "s1 edge6"));
    tbl.push_back(mk(4'hF, 10'h201, 4'h0, 3, 0, 4'h0, 10'h201, 4'h0, 0, "s1 settle"));
    // Key 0 press then release; sticky flag survives release.
    tbl.push_back(mk(4'hE, 10'h201, 4'h0, 5, 0, 4'h0, 10'h201, 4'h0, 0, "s2 pre"));
    tbl.push_back(mk(4'hE, 10'h201, 4'h0, 1, 0, 4'h1, 10'h201, 4'h1, 1, "s2 press"));
    tbl.push_back(mk(4'hF, 10'h201, 4'h0, 8, 0, 4'h0, 10'h201, 4'h1, 1, "s2 release"));
    // Glitches of 3 cycles on key 1 never reach the output.
    for (int g = 0; g < 5; g++) begin
      tbl.push_back(mk(4'hD, 10'h201, 4'h0, 3, 0, 4'h0, 10'h201, 4'h1, 0, "s3 glitch lo"));
      tbl.push_back(mk(4'hF, 10'h201, 4'h0, 2, 0, 4'h0, 10'h201, 4'h1, 0, "s3 glitch hi"));
    end
    tbl.push_back(mk(4'hD, 10'h201, 4'h0, 6, 0, 4'h2, 10'h201, 4'h3, 1, "s3 hold"));
    // Clear alone, then clear coinciding with a new press (set wins).
    tbl.push_back(mk(4'hD, 10'h201, 4'h1, 1, 0, 4'h2, 10'h201, 4'h2, 0, "s4 clr"));
    tbl.push_back(mk(4'hC, 10'h201, 4'h0, 5, 0, 4'h2, 10'h201, 4'h2, 0, "s4 pre"));
    tbl.push_back(mk(4'hC, 10'h201, 4'h1, 1, 0, 4'h3, 10'h201, 4'h3, 1, "s4 set+clr"));
    tbl.push_back(mk(4'hC, 10'h201, 4'h0, 2, 0, 4'h3, 10'h201, 4'h3, 0, "s4 hold"));
    tbl.push_back(mk(4'hC, 10'h201, 4'h2, 1, 0, 4'h3, 10'h201, 4'h1, 0, "s4 clr1"));
    // Switch and key change together: one pulse.
    tbl.push_back(mk(4'h8, 10'h209, 4'h0, 5, 0, 4'h3, 10'h201, 4'h1, 0, "s5 pre"));
    tbl.push_back(mk(4'h8, 10'h209, 4'h0, 1, 0, 4'h7, 10'h209, 4'h5, 1, "s5 edge6"));
    tbl.push_back(mk(4'h8, 10'h209, 4'h0, 3, 0, 4'h7, 10'h209, 4'h5, 0, "s5 settle"));
    tbl.push_back(mk(4'hF, 10'h201, 4'h0, 8, 0, 4'h0, 10'h201, 4'h5, 1, "s5 release"));
    // Reset in the middle of a key 0 count; counting restarts after release.
    tbl.push_back(mk(4'hE, 10'h201, 4'h0, 4, 0, 4'h0, 10'h201, 4'h5, 0, "s6 count"));
    tbl.push_back(mk(4'hE, 10'h201, 4'h0, 5, 1, 4'h0, 10'h000, 4'h0, 0, "s6 post pre"));
    tbl.push_back(mk(4'hE, 10'h201, 4'h0, 1, 0, 4'h1, 10'h201, 4'h1, 1, "s6 edge6"));

    @(negedge clk_clk);
    @(negedge clk_clk);
    check("reset board_key", int'(board_key), 0);
    check("reset board_sw", int'(board_sw), 0);
    check("reset key_press", int'(key_press), 0);
    check("reset input_changed", int'(input_changed), 0);
    reset_reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
